// File: rtl/cla_div_pkg.sv
// Shared constants and state encoding for the CLA-based sequential divider.
package cla_div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/cla8_sub_stage.sv
// Trial subtraction rem - divisor computed as rem + ~divisor + 1 on a
// carry-lookahead network; the final carry-out is the not-borrow flag.
module cla8_sub_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    logic [WIDTH-1:0] b_inv_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH:0]   c_s;
    logic             term_s;
    logic             prod_s;

    assign b_inv_s = ~divisor;
    assign g_s     = rem_in[WIDTH-1:0] & b_inv_s;
    assign p_s     = rem_in[WIDTH-1:0] ^ b_inv_s;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, cin = 1
    always_comb begin
        c_s    = '0;
        term_s = 1'b0;
        prod_s = 1'b0;
        c_s[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            term_s = g_s[i];
            prod_s = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                term_s = term_s | (prod_s & g_s[j]);
                prod_s = prod_s & p_s[j];
            end
            c_s[i+1] = term_s | prod_s;
        end
    end

    assign diff = p_s ^ c_s[WIDTH-1:0];
    // A set top bit means the shifted remainder already exceeds any divisor.
    assign no_borrow = c_s[WIDTH] | rem_in[WIDTH];

endmodule

// File: rtl/cla8_seq_divider.sv
// Multi-cycle restoring divider, one CLA trial subtraction per clock.
// Optional two's-complement operation is enabled by defining CLA_DIV_SIGNED_EN.
module cla8_seq_divider
    import cla_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    div_state_e       state_r;
    div_state_e       state_nx_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] dividend_sr_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_sr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             no_borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quot_next_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] quot_res_s;
    logic [WIDTH-1:0] rem_res_s;

    assign rem_shift_s = {rem_r, dividend_sr_r[WIDTH-1]};

    cla8_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .rem_in    (rem_shift_s),
        .divisor   (divisor_r),
        .diff      (diff_s),
        .no_borrow (no_borrow_s)
    );

    assign rem_next_s  = no_borrow_s ? diff_s : rem_shift_s[WIDTH-1:0];
    assign quot_next_s = {quot_sr_r[WIDTH-2:0], no_borrow_s};

`ifdef CLA_DIV_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    assign a_mag_s    = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag_s    = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    // -2^(W-1) / -1 yields magnitude 2^(W-1), which already reads as 0x80 unnegated.
    assign quot_res_s = neg_q_r ? (~quot_next_s + WIDTH'(1)) : quot_next_s;
    assign rem_res_s  = neg_r_r ? (~rem_next_s + WIDTH'(1)) : rem_next_s;

    // Operand sign flags captured with the magnitudes on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start && (divisor != '0)) begin
            neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_r <= dividend[WIDTH-1];
        end else begin
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end
`else
    assign a_mag_s    = dividend;
    assign b_mag_s    = divisor;
    assign quot_res_s = quot_next_s;
    assign rem_res_s  = rem_next_s;
`endif

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == LAST_CNT) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_RUN);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Shift/subtract datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_sr_r <= '0;
            divisor_r     <= '0;
            rem_r         <= '0;
            quot_sr_r     <= '0;
            count_r       <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            dbz_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (divisor == '0)) begin
                        quotient_r  <= '1;
                        remainder_r <= dividend;
                        dbz_r       <= 1'b1;
                    end else if (start) begin
                        dividend_sr_r <= a_mag_s;
                        divisor_r     <= b_mag_s;
                        rem_r         <= '0;
                        quot_sr_r     <= '0;
                        count_r       <= '0;
                        dbz_r         <= 1'b0;
                    end else begin
                        dbz_r <= dbz_r;
                    end
                end
                ST_RUN: begin
                    rem_r         <= rem_next_s;
                    dividend_sr_r <= {dividend_sr_r[WIDTH-2:0], 1'b0};
                    quot_sr_r     <= quot_next_s;
                    count_r       <= count_r + CW'(1);
                    if (count_r == LAST_CNT) begin
                        quotient_r  <= quot_res_s;
                        remainder_r <= rem_res_s;
                    end else begin
                        quotient_r  <= quotient_r;
                    end
                end
                default: begin
                    dbz_r <= dbz_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_cla8_seq_divider.sv
// Self-checking bench for cla8_seq_divider: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_cla8_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fails  = 0;

    cla8_seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic z);
`ifdef CLA_DIV_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 8'h00; z = 1'b0;
        end else begin
            q = 8'(sa / sb); r = 8'(sa % sb); z = 1'b0;
        end
`else
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
`endif
    endfunction

    // Issue one division, measure latency/busy, check results and done width.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input string tag, input int inject_at);
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        int         lat;
        int         bcnt;
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (lat == inject_at) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_val({tag, "_latency"}, lat, ez ? 0 : 8);
        check_val({tag, "_busy_cycles"}, bcnt, ez ? 0 : 8);
        check_val({tag, "_quotient"}, quotient, eq);
        check_val({tag, "_remainder"}, remainder, er);
        check_val({tag, "_dbz"}, div_by_zero, ez);
        @(posedge clk); #1;
        check_val({tag, "_done_width"}, done, 1'b0);
        check_val({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_quotient", quotient, 8'd0);
        check_val("rst_remainder", remainder, 8'd0);
        check_val("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        run_div(8'd100, 8'd7, "d100_7", -1);
        check_val("d100_7_q_lit", quotient, 8'd14);
        check_val("d100_7_r_lit", remainder, 8'd2);
        run_div(8'd255, 8'd1, "d255_1", -1);
        run_div(8'd3, 8'd200, "d3_200", -1);
        run_div(8'd255, 8'd255, "d255_255", -1);
        run_div(8'd5, 8'd0, "d5_0", -1);
        check_val("d5_0_q_lit", quotient, 8'hFF);
        check_val("d5_0_r_lit", remainder, 8'h05);
        run_div(8'd9, 8'd3, "d9_3", -1);
        check_val("d9_3_dbz_lit", div_by_zero, 1'b0);

        // start raised during RUN must be ignored
        run_div(8'd100, 8'd7, "ignore_start", 2);
        check_val("ignore_start_q_lit", quotient, 8'd14);
        run_div(8'd50, 8'd5, "d50_5", -1);
        repeat (3) @(posedge clk);
        #1;
        check_val("hold_quotient", quotient, 8'd10);
        check_val("hold_remainder", remainder, 8'd0);

        // Asynchronous reset in RUN cycle 4 aborts without done
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_quotient", quotient, 8'd0);
        check_val("abort_remainder", remainder, 8'd0);
        check_val("abort_dbz", div_by_zero, 1'b0);
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_val("abort_no_done", done_seen, 0);
        run_div(8'd77, 8'd8, "d77_8", -1);

`ifdef CLA_DIV_SIGNED_EN
        run_div(8'h9C, 8'd7, "s_m100_7", -1);
        check_val("s_m100_7_q_lit", quotient, 8'hF2);
        check_val("s_m100_7_r_lit", remainder, 8'hFE);
        run_div(8'd100, 8'hF9, "s_100_m7", -1);
        check_val("s_100_m7_q_lit", quotient, 8'hF2);
        check_val("s_100_m7_r_lit", remainder, 8'h02);
        run_div(8'h80, 8'hFF, "s_m128_m1", -1);
        check_val("s_m128_m1_q_lit", quotient, 8'h80);
        check_val("s_m128_m1_r_lit", remainder, 8'h00);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_div(ra, rb, $sformatf("rnd%0d", i), -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
